// File: rtl/register_file_mp.sv
// register_file_mp: parametrised register file with two combinational read ports, two clocked
// write ports (port 1 has priority), an optional hard-wired zero register, optional write-through
// bypass, and a per-register busy scoreboard for the pipeline's hazard logic.
//
// Ports:
//   clk_i, rst_ni                       clock (rising edge) and async active-low reset
//   wr_en{1,2}_i, write_reg{1,2}_i,
//   write_data{1,2}_i                   write ports; both may write in the same cycle
//   read_reg{1,2}_i -> read_data{1,2}_o combinational read ports
//   busy_set_i, busy_reg_i              mark a register as having a pending write
//   read_busy{1,2}_o                    busy bit of the addressed register (pre-edge state)
//   collision_o                         registered: both ports hit the same address last edge
module register_file_mp #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter bit          ZERO_REG   = 1'b1,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en1_i,
   input  logic [ADDR_WIDTH-1:0] write_reg1_i,
   input  logic [DATA_WIDTH-1:0] write_data1_i,
   input  logic                  wr_en2_i,
   input  logic [ADDR_WIDTH-1:0] write_reg2_i,
   input  logic [DATA_WIDTH-1:0] write_data2_i,
   input  logic [ADDR_WIDTH-1:0] read_reg1_i,
   input  logic [ADDR_WIDTH-1:0] read_reg2_i,
   output logic [DATA_WIDTH-1:0] read_data1_o,
   output logic [DATA_WIDTH-1:0] read_data2_o,
   input  logic                  busy_set_i,
   input  logic [ADDR_WIDTH-1:0] busy_reg_i,
   output logic                  read_busy1_o,
   output logic                  read_busy2_o,
   output logic                  collision_o
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [Depth-1:0]      busy_q, busy_d;
   logic                  collision_q, collision_d;

   logic zero1, zero2, same_addr;
   logic we1_eff, we2_eff;

   // Writes that actually land after the zero-register and collision rules.
   assign zero1     = ZERO_REG && (write_reg1_i == '0);
   assign zero2     = ZERO_REG && (write_reg2_i == '0);
   assign same_addr = (write_reg1_i == write_reg2_i);
   assign we1_eff   = wr_en1_i && !zero1;
   assign we2_eff   = wr_en2_i && !zero2 && !(wr_en1_i && same_addr);

   // An overlap on the zero register is not a real conflict.
   assign collision_d = wr_en1_i && wr_en2_i && same_addr && !zero1;

   always_comb begin
      busy_d = busy_q;
      for (int unsigned r = 0; r < Depth; r++) begin
         if (busy_set_i && (busy_reg_i == ADDR_WIDTH'(r))) begin
            busy_d[r] = 1'b1;
         end else if ((we1_eff && (write_reg1_i == ADDR_WIDTH'(r))) ||
                      (we2_eff && (write_reg2_i == ADDR_WIDTH'(r)))) begin
            busy_d[r] = 1'b0;
         end
      end
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         busy_q      <= '0;
         collision_q <= 1'b0;
      end else begin
         if (we1_eff) begin
            mem_q[write_reg1_i] <= write_data1_i;
         end
         if (we2_eff) begin
            mem_q[write_reg2_i] <= write_data2_i;
         end
         busy_q      <= busy_d;
         collision_q <= collision_d;
      end
   end

   logic [ADDR_WIDTH-1:0] rd_addr [2];
   logic [DATA_WIDTH-1:0] rd_data [2];

   assign rd_addr[0] = read_reg1_i;
   assign rd_addr[1] = read_reg2_i;

   // Bypass is suppressed while reset is held so the ports read zero immediately.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = mem_q[rd_addr[p]];
         if (BYPASS && rst_ni) begin
            if (we2_eff && (write_reg2_i == rd_addr[p])) begin
               rd_data[p] = write_data2_i;
            end
            if (we1_eff && (write_reg1_i == rd_addr[p])) begin
               rd_data[p] = write_data1_i;
            end
         end
         if (ZERO_REG && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
         end
      end
   end

   assign read_data1_o = rd_data[0];
   assign read_data2_o = rd_data[1];
   assign read_busy1_o = busy_q[read_reg1_i];
   assign read_busy2_o = busy_q[read_reg2_i];
   assign collision_o  = collision_q;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file, successor to the fixed 8×16 single-write register file used by the experiment datapath. It provides two combinational read ports, two clocked write ports with fixed priority, optional hard-wired zero register, optional write-through bypass and a per-register busy scoreboard for the pipelined datapath's hazard logic. It sits between decode (read/issue) and write-back (two result buses).

## Interface
- DATA_WIDTH, 16, bits per register
- ADDR_WIDTH, 3, register address bits; depth = 2**ADDR_WIDTH
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: read port returns same-cycle write data for a matching address
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en1  in  1  write port 1 enable (high-level)
- write_reg1  in  ADDR_WIDTH  write port 1 address
- write_data1  in  DATA_WIDTH  write port 1 data
- wr_en2  in  1  write port 2 enable
- write_reg2  in  ADDR_WIDTH  write port 2 address
- write_data2  in  DATA_WIDTH  write port 2 data
- read_reg1  in  ADDR_WIDTH  read port 1 address
- read_reg2  in  ADDR_WIDTH  read port 2 address
- read_data1  out  DATA_WIDTH  read port 1 data (combinational)
- read_data2  out  DATA_WIDTH  read port 2 data (combinational)
- busy_set  in  1  mark busy_reg as having a pending write
- busy_reg  in  ADDR_WIDTH  register to mark busy
- read_busy1  out  1  busy bit of read_reg1 (combinational)
- read_busy2  out  1  busy bit of read_reg2 (combinational)
- collision  out  1  registered pulse: both write ports hit same address last cycle

## Operation
- Storage: 2**ADDR_WIDTH × DATA_WIDTH registers, busy[2**ADDR_WIDTH-1:0].
- Write: on rising clk, port with wr_enN=1 stores write_dataN at write_regN. Both enabled, different addresses: both written.
- Collision (both enabled, same address): port 1 wins; port 2 discarded; collision=1 for the following cycle.
- ZERO_REG=1: writes to address 0 dropped (no collision flagged if the only overlap is address 0); read of address 0 returns 0.
- Read: read_dataN = array[read_regN], combinational.
- BYPASS=1: if a write port is enabled for read_regN this cycle, read_dataN = that port's write data (port 1 over port 2); address 0 with ZERO_REG=1 still returns 0. BYPASS=0: value visible only after the edge.
- Scoreboard, per register r, at each edge:
  - busy_set && busy_reg==r: busy[r] ← 1 (set wins over same-cycle clear).
  - else any effective write to r (after collision/zero rules): busy[r] ← 0.
  - else hold.
  - ZERO_REG=1: busy[0] stays 0.
- read_busyN = busy[read_regN]; not bypassed (reflects state before the edge).

## Timing
- Reset (rst_n=0, asynchronous, immediate): all registers 0, all busy 0, collision 0; read_data1/2 = 0 and read_busy1/2 = 0 while held. Writes and busy_set ignored while rst_n=0.
- Reset release: first active edge is the first edge with rst_n=1 sampled.
- Write latency: 1 edge to array; 0 cycles to read port with BYPASS=1.
- Busy latency: set/clear visible after the edge they occur on.
- collision: asserted exactly one cycle, the cycle after the colliding edge; consecutive collisions keep it high.
- Reset asserted mid-write: that write is lost; array reads 0.

## Test plan
- Reset: write 16'hf000 to r3, pulse rst_n low mid-cycle -> read_data1 (read_reg1=3) = 16'h0000 immediately, busy all 0, collision 0.
- Basic + bypass: wr_en1=1, r3←16'hf000, read_reg1=3 same cycle -> read_data1=16'hf000 before edge (BYPASS=1); with BYPASS=0 -> 16'h0000 before edge, 16'hf000 after.
- Dual write: port1 r2←16'h0f00, port2 r5←16'h00f0 same edge -> read r2=16'h0f00, r5=16'h00f0, collision=0.
- Collision: both ports r4, port1=16'h1111, port2=16'h2222 -> r4=16'h1111, collision=1 next cycle only.
- Zero register: write r0←16'hffff, busy_set r0 -> read r0=16'h0000, read_busy=0, collision 0 even if both ports target r0.
- Scoreboard: busy_set r6 -> read_busy1=1 next cycle; write r6 with busy_set r6 same edge -> stays 1; write r6 alone -> 0 next cycle.
